// File: rtl/mem_access_if.sv
// Bundle of request/response handshake and word-memory port signals for mem_access_unit.
// The slave side is the load/store unit; the master side is the datapath plus memory.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller turning byte/half/word requests into whole-word memory accesses,
// with read-modify-write for sub-word stores and fault rejection at acceptance.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input logic         clk,
  input logic         reset,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_next;
  logic        write_q, fault_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, old_q;
  logic        illegal, misaligned, out_of_range, fault_now, accept;
  logic [31:0] shifted, load_val, store_val;

  always_comb begin
    illegal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = bus.req_write;
      default:                illegal = 1'b1;
    endcase
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = bus.req_addr >= MEM_BYTES;
    fault_now    = illegal || misaligned || out_of_range;
    accept       = bus.req_valid && reset && (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      old_q    <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q  <= bus.req_write;
        fault_q  <= fault_now;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (state == RD) begin
        old_q <= bus.mem_dout;
      end
    end
  end

  // Lane extraction for loads and lane merge into the old word for sub-word stores.
  always_comb begin
    shifted = old_q >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = old_q;
    endcase
    store_val = old_q;
    case (funct3_q[1:0])
      2'b00:   store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_val = wdata_q;
    endcase
  end

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.resp_fault = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_din    = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (fault_now)
            state_next = RESP;
          else if (bus.req_write && (bus.req_funct3[1:0] == 2'b10))
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {addr_q[31:2], 2'b00};
        state_next   = write_q ? WR : RESP;
      end
      WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_din   = store_val;
        state_next    = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = fault_q;
        bus.resp_rdata = (write_q || fault_q) ? 32'h0 : load_val;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Holding reset low silences every output immediately, not only after the next edge.
    if (!reset) begin
      state_next     = IDLE;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'h0;
      bus.resp_fault = 1'b0;
      bus.mem_addr   = 32'h0;
      bus.mem_din    = 32'h0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: word-addressed memory model plus one task per scenario.
module tb_mem_access_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:16383];
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          both_cycles = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_din = 32'h0;

  mem_access_if bus ();

  mem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_dout = bus.mem_read ? mem[bus.mem_addr[15:2]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_read) rd_cycles++;
    if (bus.mem_read && bus.mem_write) both_cycles++;
    if (bus.mem_write) begin
      wr_cycles++;
      last_wr_addr = bus.mem_addr;
      last_wr_din  = bus.mem_din;
      mem[bus.mem_addr[15:2]] <= bus.mem_din;
    end
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic fault, output int lat);
    int guard;
    rdata = 32'h0;
    fault = 1'b0;
    lat   = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
        lat   = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000",
                         {bus.resp_valid, bus.resp_fault, bus.mem_read, bus.mem_write});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_din, bus.resp_rdata} !== 96'h0) begin
      errors++; $display("[TB] FAIL reset_buses: got %h %h %h expected zeros",
                         bus.mem_addr, bus.mem_din, bus.resp_rdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd;
    logic        flt;
    int          lat, wr0, rd0;
    wr0 = wr_cycles;
    rd0 = rd_cycles;
    do_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, rd, flt, lat);
    checks++;
    if ({flt, lat} !== {1'b0, 32'd2} || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL sw_resp: got fault %b lat %0d rdata %h expected 0 2 0", flt, lat, rd);
    end
    checks++;
    if (wr_cycles - wr0 != 1 || rd_cycles != rd0 || last_wr_addr !== 32'h40 || last_wr_din !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL sw_mem: got writes %0d reads %0d addr %h din %h expected 1 0 00000040 deadbeef",
                         wr_cycles - wr0, rd_cycles - rd0, last_wr_addr, last_wr_din);
    end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, flt, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 1'b0 || lat != 2) begin
      errors++; $display("[TB] FAIL lw_round_trip: got %h fault %b lat %0d expected deadbeef 0 2", rd, flt, lat);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4]   = '{32'h42, 32'h43, 32'h42, 32'h40};
    logic [31:0] exp_v [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [31:0] rd;
    logic        flt;
    int          lat;
    do_req(1'b1, 3'b010, 32'h40, 32'h80FF7F01, rd, flt, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, rd, flt, lat);
      checks++;
      if (rd !== exp_v[i] || flt !== 1'b0 || lat != 2) begin
        errors++; $display("[TB] FAIL load_%0d: got %h fault %b lat %0d expected %h 0 2", i, rd, flt, lat, exp_v[i]);
      end
    end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] rd;
    logic        flt;
    int          lat, wr0, rd0;
    mem[32'h80 >> 2] = 32'h11223344;
    wr0 = wr_cycles;
    rd0 = rd_cycles;
    do_req(1'b1, 3'b000, 32'h81, 32'hFFFFFFAA, rd, flt, lat);
    checks++;
    if (lat != 3 || flt !== 1'b0 || last_wr_din !== 32'h1122AA44 || last_wr_addr !== 32'h80) begin
      errors++; $display("[TB] FAIL sb_rmw: got lat %0d fault %b din %h addr %h expected 3 0 1122aa44 00000080",
                         lat, flt, last_wr_din, last_wr_addr);
    end
    checks++;
    if (wr_cycles - wr0 != 1 || rd_cycles - rd0 != 1) begin
      errors++; $display("[TB] FAIL sb_cycles: got writes %0d reads %0d expected 1 1", wr_cycles - wr0, rd_cycles - rd0);
    end
    do_req(1'b1, 3'b001, 32'h82, 32'h1234BEEF, rd, flt, lat);
    checks++;
    if (lat != 3 || last_wr_din !== 32'hBEEFAA44) begin
      errors++; $display("[TB] FAIL sh_rmw: got lat %0d din %h expected 3 beefaa44", lat, last_wr_din);
    end
    @(negedge clk);
    checks++;
    if (mem[32'h80 >> 2] !== 32'hBEEFAA44) begin
      errors++; $display("[TB] FAIL sh_mem: got %h expected beefaa44", mem[32'h80 >> 2]);
    end
  endtask

  task automatic test_faults();
    logic        w  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] ad [5] = '{32'h42, 32'h81, 32'h40, 32'h40, 32'h10000};
    logic [31:0] rd, snap40, snap80;
    logic        flt;
    int          lat, wr0, rd0;
    snap40 = mem[32'h40 >> 2];
    snap80 = mem[32'h80 >> 2];
    wr0 = wr_cycles;
    rd0 = rd_cycles;
    for (int i = 0; i < 5; i++) begin
      do_req(w[i], f3[i], ad[i], 32'h0BADF00D, rd, flt, lat);
      checks++;
      if (flt !== 1'b1 || lat != 1 || rd !== 32'h0) begin
        errors++; $display("[TB] FAIL fault_%0d: got fault %b lat %0d rdata %h expected 1 1 0", i, flt, lat, rd);
      end
    end
    @(negedge clk);
    checks++;
    if (wr_cycles != wr0 || rd_cycles != rd0) begin
      errors++; $display("[TB] FAIL fault_mem_cycles: got writes %0d reads %0d expected 0 0", wr_cycles - wr0, rd_cycles - rd0);
    end
    checks++;
    if (mem[32'h40 >> 2] !== snap40 || mem[32'h80 >> 2] !== snap80) begin
      errors++; $display("[TB] FAIL fault_mem_data: got %h %h expected %h %h",
                         mem[32'h40 >> 2], mem[32'h80 >> 2], snap40, snap80);
    end
  endtask

  task automatic test_reset_mid_store();
    int wr0;
    mem[32'hC0 >> 2] = 32'hCAFEF00D;
    wr0 = wr_cycles;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'hC1;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'hC0) begin
      errors++; $display("[TB] FAIL rmw_rd_phase: got read %b addr %h expected 1 000000c0", bus.mem_read, bus.mem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_read, bus.mem_write} !== 4'b0000 ||
        {bus.mem_addr, bus.mem_din, bus.resp_rdata} !== 96'h0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %b %h %h %h expected all 0",
                         {bus.req_ready, bus.resp_valid, bus.mem_read, bus.mem_write},
                         bus.mem_addr, bus.mem_din, bus.resp_rdata);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cycles != wr0 || mem[32'hC0 >> 2] !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL mid_reset_no_write: got writes %0d word %h expected 0 cafef00d",
                         wr_cycles - wr0, mem[32'hC0 >> 2]);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_idle: got ready %b resp %b expected 1 0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3 [3]    = '{3'b010, 3'b100, 3'b000};
    logic [31:0] ad [3]    = '{32'h40, 32'h41, 32'h43};
    logic [31:0] exp_v [3] = '{32'h80FF7F01, 32'h0000007F, 32'hFFFFFF80};
    int acc, resp, last_acc;
    mem[32'h40 >> 2] = 32'h80FF7F01;
    acc = 0;
    resp = 0;
    last_acc = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = f3[0];
    bus.req_addr   = ad[0];
    for (int c = 0; c < 20 && resp < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.resp_valid) begin
        checks++;
        if (resp >= 3 || bus.resp_rdata !== exp_v[resp] || bus.resp_fault !== 1'b0 || bus.req_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_resp_%0d: got %h fault %b ready %b expected %h 0 0",
                             resp, bus.resp_rdata, bus.resp_fault, bus.req_ready, exp_v[resp % 3]);
        end
        resp++;
      end
      if (bus.req_ready && bus.req_valid) begin
        if (acc > 0) begin
          checks++;
          if (c - last_acc != 3) begin
            errors++; $display("[TB] FAIL b2b_gap_%0d: got %0d cycles expected 3", acc, c - last_acc);
          end
        end
        last_acc = c;
        acc++;
        @(posedge clk);
        #1;
        if (acc < 3) begin
          bus.req_funct3 = f3[acc];
          bus.req_addr   = ad[acc];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (acc != 3 || resp != 3) begin
      errors++; $display("[TB] FAIL b2b_counts: got accepts %0d responses %0d expected 3 3", acc, resp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_word_round_trip();
    test_loads();
    test_sub_word_store();
    test_faults();
    test_reset_mid_store();
    test_back_to_back();
    checks++;
    if (both_cycles != 0) begin
      errors++; $display("[TB] FAIL read_write_overlap: got %0d cycles expected 0", both_cycles);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
